md_unit: RTL and testbench

Iterative multiply/divide responder for the MIPS execute stage. The ALU issues MULT/MULTU/DIV/DIVU operands and a one-cycle start request. This block computes the 64-bit product, or the quotient and remainder, over a fixed multi-cycle latency. It holds the results in architectural HI/LO registers, which MFHI/MFLO read and MTHI/MTLO write. Decode/control uses `busy` to stall any later instruction that touches HI/LO.

---
 rtl/md_pkg.sv | 20 ++
 rtl/md_signfix.sv | 13 +
 rtl/md_unit.sv | 140 ++++++++++++++
 tb/tb_md_unit.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings and timing constants for the multiply/divide unit.
// Op codes match funct[1:0] of MULT/MULTU/DIV/DIVU.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITER    = 32;
    localparam int MD_LATENCY = 34;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_t;

endpackage

// File: rtl/md_signfix.sv
// Conditional two's-complement negate; doubles as absolute value when neg
// is driven by the operand's own sign bit.
module md_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? -x : x;

endmodule

// File: rtl/md_unit.sv
// Iterative 32-cycle multiply/divide with architectural HI/LO registers.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; MTHI/MTLO writes accepted here
//   CALC    | one shift-add (mul) or shift-subtract (div) step per cycle
//   FIX     | sign correction of product / quotient / remainder
//   DONE    | commit to hi/lo, pulse done
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DW = 2 * WIDTH;

    md_state_t        state;
    logic [5:0]       cnt;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div0;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] opnd;
    logic [DW-1:0]    acc;

    logic             signed_op;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    assign signed_op = ~op[0];

    md_signfix #(.W(WIDTH)) u_abs_a (.x(a), .neg(signed_op & a[WIDTH-1]), .y(a_abs));
    md_signfix #(.W(WIDTH)) u_abs_b (.x(b), .neg(signed_op & b[WIDTH-1]), .y(b_abs));
    md_signfix #(.W(DW))    u_prod  (.x(acc), .neg(neg_q), .y(prod_fix));
    md_signfix #(.W(WIDTH)) u_quot  (.x(acc[WIDTH-1:0]), .neg(neg_q), .y(q_fix));
    md_signfix #(.W(WIDTH)) u_rem   (.x(acc[DW-1:WIDTH]), .neg(neg_r), .y(r_fix));

    // acc holds {partial, multiplier} for mul and {remainder, dividend/quotient} for div
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub;
    logic             rem_ge;

    assign mul_sum = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    assign rem_sh  = acc[DW-1:WIDTH-1];
    assign rem_ge  = rem_sh >= {1'b0, opnd};
    assign rem_sub = rem_sh[WIDTH-1:0] - opnd;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            a_raw  <= '0;
            opnd   <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (start && !flush) begin
                    state  <= ST_CALC;
                    busy   <= 1'b1;
                    cnt    <= '0;
                    is_div <= op[1];
                    neg_q  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_r  <= signed_op & a[WIDTH-1];
                    div0   <= (b == '0);
                    a_raw  <= a;
                    opnd   <= op[1] ? b_abs : a_abs;
                    acc    <= op[1] ? {{WIDTH{1'b0}}, a_abs} : {{WIDTH{1'b0}}, b_abs};
                end else begin
                    busy <= 1'b0;
                    if (!start) begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
            end else if (flush) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ST_CALC: begin
                        if (is_div)
                            acc <= rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                                          : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                        else
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(MD_ITER - 1))
                            state <= ST_FIX;
                    end
                    ST_FIX: begin
                        if (!is_div)
                            acc <= prod_fix;
                        else if (div0)
                            acc <= {a_raw, {WIDTH{1'b1}}};
                        else
                            acc <= {r_fix, q_fix};
                        state <= ST_DONE;
                    end
                    ST_DONE: begin
                        hi    <= acc[DW-1:WIDTH];
                        lo    <= acc[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table plus random ops through a
// result scoreboard, then hand-written abort/overlap sequences.
module tb_md_unit;
    import md_pkg::*;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush, hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    always #5 clock = ~clock;

    md_unit #(.WIDTH(32)) dut (
        .clock(clock), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
    } exp_t;

    exp_t scb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        longint      sx, sy;
        logic [63:0] p;
        logic [63:0] q, r;
        if (o[0]) begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end else begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end
        if (!o[1]) begin
            p = 64'(sx * sy);
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (y == 32'd0) begin
            e.hi = x;
            e.lo = 32'hFFFF_FFFF;
        end else begin
            q = 64'(sx / sy);
            r = 64'(sx % sy);
            e.hi = r[31:0];
            e.lo = q[31:0];
        end
        return e;
    endfunction

    // Start sampled at the next edge (E0); returns #1 after E0 with operands scrambled.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit push, input exp_t e);
        @(negedge clock);
        start = 1'b1; op = o; a = x; b = y;
        if (push) scb.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
    endtask

    task automatic wait_done(input int limit, output int lat);
        int i;
        lat = -1;
        i = 1;
        while (lat < 0 && i <= limit) begin
            @(posedge clock);
            #1;
            if (done) lat = i;
            i++;
        end
    endtask

    task automatic count_dones(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
            if (done) c++;
        end
    endtask

    task automatic finish_op(input string nm, input int exp_lat);
        int   lat;
        exp_t e;
        wait_done(60, lat);
        chk({nm, " latency"}, 64'(lat), 64'(exp_lat));
        if (scb.size() == 0) begin
            chk({nm, " scoreboard empty"}, 64'(0), 64'(1));
        end else begin
            e = scb.pop_front();
            if (lat >= 0) begin
                chk({nm, " hi"}, 64'(hi), 64'(e.hi));
                chk({nm, " lo"}, 64'(lo), 64'(e.lo));
            end
        end
    endtask

    vec_t vecs[11];
    exp_t e0;
    exp_t prev;
    int   c;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    initial begin
        vecs[0]  = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1};
        vecs[3]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
        vecs[5]  = '{MD_DIVU,  32'h0000_1234, 32'h0,        32'h0000_1234, 32'hFFFF_FFFF};
        vecs[6]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD};
        vecs[7]  = '{MD_DIV,   32'hFFFF_FFF9, 32'h0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[8]  = '{MD_MULTU, 32'h0,         32'h1234_5678, 32'h0,         32'h0};
        vecs[9]  = '{MD_DIVU,  32'hFFFF_FFFF, 32'h10,       32'h0000_000F, 32'h0FFF_FFFF};
        vecs[10] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        #12;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset hi",   64'(hi),   64'(0));
        chk("reset lo",   64'(lo),   64'(0));
        @(negedge clock);
        rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 11; i++) begin
            e0.hi = vecs[i].hi;
            e0.lo = vecs[i].lo;
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, e0);
            chk($sformatf("vec%0d busy after E0", i), 64'(busy), 64'(1));
            finish_op($sformatf("vec%0d", i), 34);
            chk($sformatf("vec%0d busy at done", i), 64'(busy), 64'(1));
            @(posedge clock);
            #1;
            chk($sformatf("vec%0d busy after E35", i), 64'(busy), 64'(0));
        end

        // Random ops against the arithmetic model
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            issue(ro, ra, rb, 1'b1, model(ro, ra, rb));
            finish_op($sformatf("rnd%0d op%0d", i, ro), 34);
            @(posedge clock);
        end

        // MTHI/MTLO in IDLE
        @(negedge clock);
        lo_we = 1'b1; wdata = 32'h0000_ABCD;
        @(posedge clock);
        #1;
        lo_we = 1'b0;
        chk("mtlo", 64'(lo), 64'h0000_ABCD);
        @(negedge clock);
        hi_we = 1'b1; wdata = 32'h0000_5555;
        @(posedge clock);
        #1;
        hi_we = 1'b0;
        chk("mthi", 64'(hi), 64'h0000_5555);
        chk("mthi keeps lo", 64'(lo), 64'h0000_ABCD);

        // Flush at E20, with an MTHI attempt while busy
        prev.hi = hi; prev.lo = lo;
        issue(MD_MULTU, 32'd1000, 32'd1000, 1'b0, e0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        hi_we = 1'b0;
        chk("mthi while busy dropped", 64'(hi), 64'(prev.hi));
        repeat (14) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0;
        chk("flush busy", 64'(busy), 64'(0));
        count_dones(45, c);
        chk("flush no done", 64'(c), 64'(0));
        chk("flush hi kept", 64'(hi), 64'(prev.hi));
        chk("flush lo kept", 64'(lo), 64'(prev.lo));

        // Second start at E10 is ignored
        issue(MD_DIVU, 32'd100, 32'd7, 1'b1, model(MD_DIVU, 32'd100, 32'd7));
        repeat (9) @(posedge clock);
        @(negedge clock);
        start = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd3;
        @(posedge clock);
        #1;
        start = 1'b0;
        finish_op("restart ignored", 24);
        count_dones(40, c);
        chk("restart single done", 64'(c), 64'(0));

        // Back-to-back: start held through DONE, accepted again at E35
        @(negedge clock);
        start = 1'b1; op = MD_MULT; a = 32'hFFFF_FF00; b = 32'd77;
        scb.push_back(model(MD_MULT, 32'hFFFF_FF00, 32'd77));
        scb.push_back(model(MD_MULT, 32'hFFFF_FF00, 32'd77));
        @(posedge clock);
        #1;
        finish_op("b2b first", 34);
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("b2b busy held", 64'(busy), 64'(1));
        finish_op("b2b second", 34);
        @(posedge clock);

        // Asynchronous reset at E15
        chk("pre-reset hi nonzero", 64'(hi != 32'd0), 64'(1));
        issue(MD_DIV, 32'd500, 32'd3, 1'b0, e0);
        repeat (15) @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort hi",   64'(hi),   64'(0));
        chk("abort lo",   64'(lo),   64'(0));
        @(negedge clock);
        rst_n = 1'b1;
        count_dones(45, c);
        chk("abort no done", 64'(c), 64'(0));
        chk("abort idle busy", 64'(busy), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
